// File: rtl/fcp6_pkg.sv
// Shared FCP6 definitions: bus encodings, ACK polarity, master state encoding
// and small bit-selection helpers used by both master and responder.
package fcp6_pkg;

  // ctrl line encodings (released = z)
  localparam logic [1:0] CTRL_START = 2'b01;
  localparam logic [1:0] CTRL_OWN   = 2'b10;
  localparam logic [1:0] CTRL_STOP  = 2'b11;

  // ack line: driven low means ACK; high, floating or unknown means NACK
  localparam logic       ACK_LVL    = 1'b0;

  // beat counter start value: MSB pair of a byte sits at bit 6
  localparam logic [2:0] CNT_LOAD   = 3'd6;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_HDR   = 4'd2,
    ST_HACK  = 4'd3,
    ST_TURN  = 4'd4,
    ST_WDATA = 4'd5,
    ST_WACK  = 4'd6,
    ST_RDATA = 4'd7,
    ST_RACK  = 4'd8,
    ST_STOP  = 4'd9
  } fcp6_state_e;

  // True only for a clean ACK level; x or z compare false and read as NACK.
  function automatic logic is_ack(input logic a);
    return (a == ACK_LVL);
  endfunction

  // Select the 2-bit pair of a byte that starts at bit position cnt.
  function automatic logic [1:0] pair_sel(input logic [7:0] b, input logic [2:0] cnt);
    logic [1:0] p;
    case (cnt[2:1])
      2'd3:    p = b[7:6];
      2'd2:    p = b[5:4];
      2'd1:    p = b[3:2];
      2'd0:    p = b[1:0];
      default: p = b[1:0];
    endcase
    return p;
  endfunction

endpackage

// File: rtl/fcp6_if.sv
// Request/response handshake between a client and the FCP6 master.
interface fcp6_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic       req_rw;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    input  req_valid, req_addr, req_rw, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/fcp6_beat_shifter.sv
// 2-bit beat counter plus transmit pair selection and receive pair assembly.
// The counter walks 6,4,2,0 and holds at 0; the same count indexes the byte
// being sent (header or write data) and the byte being received.
module fcp6_beat_shifter
  import fcp6_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic       i_step,
  input  logic       i_cap,
  input  logic [7:0] i_tx_byte,
  input  logic [1:0] i_rx_pair,
  output logic [1:0] o_tx_pair,
  output logic       o_last,
  output logic [7:0] o_rx_byte
);

  logic [2:0] r_cnt;
  logic [7:0] r_rx;

  // Beat counter: load to the MSB pair, step down by two, never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
    end else if (i_load) begin
      r_cnt <= CNT_LOAD;
    end else if (i_step) begin
      r_cnt <= (r_cnt >= 3'd2) ? (r_cnt - 3'd2) : 3'd0;
    end
  end

  // Receive byte: cleared per transaction, one pair written per sampled beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx <= 8'h00;
    end else if (i_clr) begin
      r_rx <= 8'h00;
    end else if (i_cap) begin
      case (r_cnt[2:1])
        2'd3:    r_rx[7:6] <= i_rx_pair;
        2'd2:    r_rx[5:4] <= i_rx_pair;
        2'd1:    r_rx[3:2] <= i_rx_pair;
        2'd0:    r_rx[1:0] <= i_rx_pair;
        default: r_rx[1:0] <= i_rx_pair;
      endcase
    end
  end

  assign o_tx_pair = pair_sel(i_tx_byte, r_cnt);
  assign o_last    = (r_cnt == 3'd0);
  assign o_rx_byte = r_rx;

endmodule

// File: rtl/fcp6_master.sv
// FCP6 bus master: one header byte, then one write or read data byte.
// State and sampling advance on posedge; bus drivers are registered on negedge
// so the lines are stable around every sampling edge.
module fcp6_master
  import fcp6_pkg::*;
#(
  parameter int MAX_RETRY = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  fcp6_if.master bus,
  inout  wire [1:0] ctrl,
  inout  wire [1:0] data,
  inout  wire       ack
);

  localparam int            RW    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  fcp6_state_e r_state, w_next;

  logic [7:0]    r_hdr;
  logic [7:0]    r_wdata;
  logic [RW-1:0] r_retry;
  logic          r_err;
  logic          r_ready;
  logic          r_rsp_valid;

  logic          w_accept, w_load, w_step, w_cap;
  logic          w_err_set, w_err_val, w_retry_inc;
  logic [7:0]    w_tx_byte;
  logic [1:0]    w_tx_pair;
  logic          w_last;
  logic [7:0]    w_rx_byte;

  logic          w_ctrl_oe, w_data_oe, w_ack_oe;
  logic [1:0]    w_ctrl_v, w_data_v;
  logic          r_ctrl_oe, r_data_oe, r_ack_oe;
  logic [1:0]    r_ctrl_v, r_data_v;

  assign w_tx_byte = (r_state == ST_HDR) ? r_hdr : r_wdata;

  fcp6_beat_shifter u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_accept),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_cap     (w_cap),
    .i_tx_byte (w_tx_byte),
    .i_rx_pair (data),
    .o_tx_pair (w_tx_pair),
    .o_last    (w_last),
    .o_rx_byte (w_rx_byte)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and per-state counter/retry/error controls.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_cap       = 1'b0;
    w_err_set   = 1'b0;
    w_err_val   = 1'b0;
    w_retry_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ready && bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = ST_START;
        end else begin
          w_next   = ST_IDLE;
        end
      end
      ST_START: begin
        w_load = 1'b1;
        w_next = ST_HDR;
      end
      ST_HDR: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next = ST_HACK;
        end else begin
          w_next = ST_HDR;
        end
      end
      ST_HACK: begin
        if (is_ack(ack)) begin
          w_next = ST_TURN;
        end else begin
          w_err_set = 1'b1;
          w_err_val = 1'b1;
          w_next    = ST_STOP;
        end
      end
      ST_TURN: begin
        w_load = 1'b1;
        if (r_hdr[0]) begin
          w_next = ST_WDATA;
        end else begin
          w_next = ST_RDATA;
        end
      end
      ST_WDATA: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next = ST_WACK;
        end else begin
          w_next = ST_WDATA;
        end
      end
      ST_WACK: begin
        if (is_ack(ack)) begin
          w_err_set = 1'b1;
          w_err_val = 1'b0;
          w_next    = ST_STOP;
        end else if (r_retry < MAX_R) begin
          w_retry_inc = 1'b1;
          w_load      = 1'b1;
          w_next      = ST_WDATA;
        end else begin
          w_err_set = 1'b1;
          w_err_val = 1'b1;
          w_next    = ST_STOP;
        end
      end
      ST_RDATA: begin
        w_cap  = 1'b1;
        w_step = 1'b1;
        if (w_last) begin
          w_next = ST_RACK;
        end else begin
          w_next = ST_RDATA;
        end
      end
      ST_RACK: begin
        w_err_set = 1'b1;
        w_err_val = 1'b0;
        w_next    = ST_STOP;
      end
      ST_STOP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, retry/error bookkeeping and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr       <= 8'h00;
      r_wdata     <= 8'h00;
      r_retry     <= '0;
      r_err       <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_ready     <= (w_next == ST_IDLE);
      r_rsp_valid <= (r_state == ST_STOP);
      if (w_accept) begin
        r_hdr   <= {bus.req_addr, bus.req_rw};
        r_wdata <= bus.req_wdata;
        r_retry <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_retry_inc) begin
          r_retry <= r_retry + RW'(1);
        end
        if (w_err_set) begin
          r_err <= w_err_val;
        end
      end
    end
  end

  // Bus drive decode: at most one of data/ack is ever enabled in a state.
  always_comb begin
    w_ctrl_oe = 1'b0;
    w_ctrl_v  = 2'b00;
    w_data_oe = 1'b0;
    w_data_v  = 2'b00;
    w_ack_oe  = 1'b0;
    case (r_state)
      ST_START: begin
        w_ctrl_oe = 1'b1;
        w_ctrl_v  = CTRL_START;
      end
      ST_HDR, ST_WDATA: begin
        w_data_oe = 1'b1;
        w_data_v  = w_tx_pair;
      end
      ST_RACK: begin
        w_ack_oe = 1'b1;
      end
      ST_STOP: begin
        w_ctrl_oe = 1'b1;
        w_ctrl_v  = CTRL_STOP;
      end
      default: begin
        w_ctrl_oe = 1'b0;
      end
    endcase
  end

  // Bus drivers update on negedge; reset releases every line at once.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_oe <= 1'b0;
      r_ctrl_v  <= 2'b00;
      r_data_oe <= 1'b0;
      r_data_v  <= 2'b00;
      r_ack_oe  <= 1'b0;
    end else begin
      r_ctrl_oe <= w_ctrl_oe;
      r_ctrl_v  <= w_ctrl_v;
      r_data_oe <= w_data_oe;
      r_data_v  <= w_data_v;
      r_ack_oe  <= w_ack_oe;
    end
  end

  assign ctrl = r_ctrl_oe ? r_ctrl_v : 2'bzz;
  assign data = r_data_oe ? r_data_v : 2'bzz;
  assign ack  = r_ack_oe  ? ACK_LVL  : 1'bz;

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_err;
  assign bus.rsp_rdata = w_rx_byte;

endmodule

// File: tb/tb_fcp6_master.sv
// Directed bench for fcp6_master with a cycle-scheduled responder model.
module tb_fcp6_master;
  import fcp6_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fcp6_if bus();
  wire [1:0] ctrl;
  wire [1:0] data;
  wire       ack;

  logic       rsp_d_oe = 1'b0;
  logic [1:0] rsp_d    = 2'b00;
  logic       rsp_a_oe = 1'b0;

  assign data = rsp_d_oe ? rsp_d : 2'bzz;
  assign ack  = rsp_a_oe ? ACK_LVL : 1'bz;
  pullup (ack);

  fcp6_master #(.MAX_RETRY(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master),
    .ctrl  (ctrl),
    .data  (data),
    .ack   (ack)
  );

  int errors = 0;
  int checks = 0;

  logic [1:0] ctrl_s [0:39];
  logic [1:0] data_s [0:39];
  logic       ack_s  [0:39];
  logic       rdy_s  [0:39];
  logic       rv_s   [0:39];
  logic       err_s  [0:39];
  logic [7:0] rd_s   [0:39];

  // Released (z) bits read as 0 so released lines compare as 2'b00.
  function automatic logic [1:0] n2(input logic [1:0] v);
    logic [1:0] r;
    r[0] = (v[0] === 1'b1);
    r[1] = (v[1] === 1'b1);
    return r;
  endfunction

  function automatic logic na(input logic v);
    return (v === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  // Issue one request and record ncyc cycles starting with the START cycle (k=0).
  task automatic run_txn(input logic [6:0] addr, input logic rw, input logic [7:0] wd,
                         input logic hdr_ack, input int nacks, input logic [7:0] rd,
                         input int ncyc);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_rw    = rw;
    bus.req_wdata = wd;
    @(posedge clk);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.req_valid = 1'b0;
        bus.req_addr  = ~addr;
        bus.req_rw    = ~rw;
        bus.req_wdata = ~wd;
      end
      rsp_a_oe = 1'b0;
      rsp_d_oe = 1'b0;
      if (k == 5 && hdr_ack) rsp_a_oe = 1'b1;
      if (rw && hdr_ack && k >= 11 && ((k - 11) % 5 == 0) && ((k - 11) / 5 == nacks))
        rsp_a_oe = 1'b1;
      if (!rw && hdr_ack && k >= 7 && k <= 10) begin
        rsp_d_oe = 1'b1;
        rsp_d    = rd[2*(10-k) +: 2];
      end
      #1;
      ctrl_s[k] = n2(ctrl);
      data_s[k] = n2(data);
      ack_s[k]  = na(ack);
      rdy_s[k]  = bus.req_ready;
      rv_s[k]   = bus.rsp_valid;
      err_s[k]  = bus.rsp_err;
      rd_s[k]   = bus.rsp_rdata;
    end
    rsp_a_oe = 1'b0;
    rsp_d_oe = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
    checks++; if (bus.rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", bus.rsp_rdata); end
    checks++; if (n2(ctrl) !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b expected released", ctrl); end
    checks++; if (na(ack) !== 1'b1) begin errors++; $display("FAIL reset_ack: got %b expected released", ack); end
    #10 rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0", bus.req_ready); end
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b expected 1", bus.req_ready); end
  endtask

  // addr 0x2A write -> header 0x55, wdata 0xA5
  task automatic test_write;
    logic [1:0] exp_d [0:14];
    logic [1:0] exp_c [0:14];
    exp_d = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10,
              2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    exp_c = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
              2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    run_txn(7'h2A, 1'b1, 8'hA5, 1'b1, 0, 8'h00, 15);
    for (int k = 0; k < 15; k++) begin
      checks++; if (data_s[k] !== exp_d[k]) begin errors++; $display("FAIL write_data[%0d]: got %b expected %b", k, data_s[k], exp_d[k]); end
      checks++; if (ctrl_s[k] !== exp_c[k]) begin errors++; $display("FAIL write_ctrl[%0d]: got %b expected %b", k, ctrl_s[k], exp_c[k]); end
      checks++; if (rv_s[k] !== (k == 13)) begin errors++; $display("FAIL write_rsp_valid[%0d]: got %b expected %b", k, rv_s[k], (k == 13)); end
      checks++; if (rdy_s[k] !== (k >= 13)) begin errors++; $display("FAIL write_ready[%0d]: got %b expected %b", k, rdy_s[k], (k >= 13)); end
    end
    checks++; if (err_s[13] !== 1'b0) begin errors++; $display("FAIL write_err: got %b expected 0", err_s[13]); end
  endtask

  // addr 0x15 read -> header 0x2A; responder returns 0x55
  task automatic test_read;
    logic [1:0] exp_d [0:14];
    exp_d = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01,
              2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    run_txn(7'h15, 1'b0, 8'hFF, 1'b1, 0, 8'h55, 15);
    for (int k = 0; k < 15; k++) begin
      checks++; if (data_s[k] !== exp_d[k]) begin errors++; $display("FAIL read_data[%0d]: got %b expected %b", k, data_s[k], exp_d[k]); end
      checks++; if (ack_s[k] !== !(k == 5 || k == 11)) begin errors++; $display("FAIL read_ack[%0d]: got %b expected %b", k, ack_s[k], !(k == 5 || k == 11)); end
    end
    for (int k = 1; k < 12; k++) begin
      checks++; if (ctrl_s[k] !== 2'b00) begin errors++; $display("FAIL read_ctrl[%0d]: got %b expected 00", k, ctrl_s[k]); end
    end
    checks++; if (ctrl_s[12] !== 2'b11) begin errors++; $display("FAIL read_stop: got %b expected 11", ctrl_s[12]); end
    checks++; if (rv_s[13] !== 1'b1) begin errors++; $display("FAIL read_rsp_valid: got %b expected 1", rv_s[13]); end
    checks++; if (rd_s[13] !== 8'h55) begin errors++; $display("FAIL read_rdata: got %h expected 55", rd_s[13]); end
    checks++; if (err_s[13] !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", err_s[13]); end
  endtask

  // ack left floating in HACK -> immediate STOP with error
  task automatic test_hdr_nack;
    logic [1:0] exp_c [0:8];
    exp_c = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    run_txn(7'h2A, 1'b1, 8'hA5, 1'b0, 0, 8'h00, 9);
    for (int k = 0; k < 9; k++) begin
      checks++; if (ctrl_s[k] !== exp_c[k]) begin errors++; $display("FAIL hnack_ctrl[%0d]: got %b expected %b", k, ctrl_s[k], exp_c[k]); end
      checks++; if (rv_s[k] !== (k == 7)) begin errors++; $display("FAIL hnack_rsp_valid[%0d]: got %b expected %b", k, rv_s[k], (k == 7)); end
    end
    for (int k = 5; k < 9; k++) begin
      checks++; if (data_s[k] !== 2'b00) begin errors++; $display("FAIL hnack_data[%0d]: got %b expected 00", k, data_s[k]); end
    end
    checks++; if (err_s[7] !== 1'b1) begin errors++; $display("FAIL hnack_err: got %b expected 1", err_s[7]); end
  endtask

  // data NACKed 4 times with MAX_RETRY=3 -> 4 bursts, STOP with error
  task automatic test_retry_exhaust;
    int beats;
    run_txn(7'h2A, 1'b1, 8'hA5, 1'b1, 4, 8'h00, 30);
    beats = 0;
    for (int k = 7; k < 30; k++) if (data_s[k] !== 2'b00) beats++;
    checks++; if (beats !== 16) begin errors++; $display("FAIL exhaust_beats: got %0d expected 16", beats); end
    for (int a = 0; a < 4; a++) begin
      checks++; if (data_s[7+5*a] !== 2'b10) begin errors++; $display("FAIL exhaust_burst[%0d]: got %b expected 10", a, data_s[7+5*a]); end
    end
    checks++; if (ctrl_s[26] !== 2'b00) begin errors++; $display("FAIL exhaust_wack_ctrl: got %b expected 00", ctrl_s[26]); end
    checks++; if (ctrl_s[27] !== 2'b11) begin errors++; $display("FAIL exhaust_stop: got %b expected 11", ctrl_s[27]); end
    checks++; if (rv_s[27] !== 1'b0) begin errors++; $display("FAIL exhaust_rv_early: got %b expected 0", rv_s[27]); end
    checks++; if (rv_s[28] !== 1'b1) begin errors++; $display("FAIL exhaust_rsp_valid: got %b expected 1", rv_s[28]); end
    checks++; if (err_s[28] !== 1'b1) begin errors++; $display("FAIL exhaust_err: got %b expected 1", err_s[28]); end
  endtask

  // one NACK then ACK -> 18 cycles (13 + 5), no error
  task automatic test_retry_once;
    run_txn(7'h2A, 1'b1, 8'hA5, 1'b1, 1, 8'h00, 20);
    checks++; if (data_s[12] !== 2'b10) begin errors++; $display("FAIL once_burst2: got %b expected 10", data_s[12]); end
    checks++; if (ctrl_s[17] !== 2'b11) begin errors++; $display("FAIL once_stop: got %b expected 11", ctrl_s[17]); end
    checks++; if (rv_s[17] !== 1'b0) begin errors++; $display("FAIL once_rv_early: got %b expected 0", rv_s[17]); end
    checks++; if (rv_s[18] !== 1'b1) begin errors++; $display("FAIL once_rsp_valid: got %b expected 1", rv_s[18]); end
    checks++; if (err_s[18] !== 1'b0) begin errors++; $display("FAIL once_err: got %b expected 0", err_s[18]); end
  endtask

  // reset asserted during the second write-data beat, then a fresh request
  task automatic test_back_to_back_reset;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 7'h2A;
    bus.req_rw    = 1'b1;
    bus.req_wdata = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rsp_a_oe = (k == 5);
    end
    #1;
    checks++; if (n2(data) !== 2'b10) begin errors++; $display("FAIL rst_pre_data: got %b expected 10", data); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (n2(data) !== 2'b00) begin errors++; $display("FAIL rst_data: got %b expected released", data); end
    checks++; if (n2(ctrl) !== 2'b00) begin errors++; $display("FAIL rst_ctrl: got %b expected released", ctrl); end
    checks++; if (na(ack) !== 1'b1) begin errors++; $display("FAIL rst_ack: got %b expected released", ack); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus.req_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid[%0d]: got %b expected 0", k, bus.rsp_valid); end
    end
    #1 rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_pre: got %b expected 0", bus.req_ready); end
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_post: got %b expected 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: got %b expected 0", bus.rsp_valid); end
    run_txn(7'h2A, 1'b1, 8'hA5, 1'b1, 0, 8'h00, 15);
    checks++; if (data_s[1] !== 2'b01) begin errors++; $display("FAIL post_hdr: got %b expected 01", data_s[1]); end
    checks++; if (data_s[8] !== 2'b10) begin errors++; $display("FAIL post_wdata: got %b expected 10", data_s[8]); end
    checks++; if (rv_s[13] !== 1'b1) begin errors++; $display("FAIL post_rsp_valid: got %b expected 1", rv_s[13]); end
    checks++; if (err_s[13] !== 1'b0) begin errors++; $display("FAIL post_err: got %b expected 0", err_s[13]); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = 7'h00;
    bus.req_rw    = 1'b0;
    bus.req_wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_hdr_nack();
    test_retry_exhaust();
    test_retry_once();
    test_back_to_back_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fcp6_master.md
FCP6_MASTER -- requirements
Module: fcp6_master

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, meaning the data-byte retransmissions allowed after NACK before abort.
REQ-002 SHALL have port clk  in  1  the single clock; bus outputs change on negedge, samples and state advance on posedge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  transaction request.
REQ-005 SHALL have port req_ready  out  1  high only in IDLE; request accepted on posedge with req_valid&&req_ready.
REQ-006 SHALL have port req_addr  in  7  target address, header bits 7:1.
REQ-007 SHALL have port req_rw  in  1  header bit 0; 1 = master write, 0 = master read.
REQ-008 SHALL have port req_wdata  in  8  write byte.
REQ-009 SHALL have port rsp_valid  out  1  one-cycle pulse at transaction end.
REQ-010 SHALL have port rsp_rdata  out  8  read byte, valid with rsp_valid on a read.
REQ-011 SHALL have port rsp_err  out  1  valid with rsp_valid; 1 = header NACK or retries exhausted.
REQ-012 SHALL have port ctrl  inout  2  01 START, 10 responder owns bus, 11 STOP, z released.
REQ-013 SHALL have port data  inout  2  payload, MSB pair first.
REQ-014 SHALL have port ack  inout  1  0 = ACK; 1, z or x = NACK.

Function
REQ-015 SHALL latch {req_addr,req_rw} as header and req_wdata on accept; later input changes are ignored.
REQ-016 SHALL use states IDLE, START, HDR, HACK, TURN, WDATA, WACK, RDATA, RACK, STOP.
REQ-017 IDLE SHALL release ctrl, data and ack, and SHALL go to START on accept.
REQ-018 START SHALL drive ctrl=01 for exactly one cycle, then go to HDR with the beat counter at 6.
REQ-019 HDR SHALL drive data=header[cnt+:2] for 4 cycles (cnt 6,4,2,0) with ctrl released, then go to HACK.
REQ-020 HACK SHALL release all lines for one cycle and sample ack at its closing posedge; NACK -> STOP with err=1; ACK -> TURN.
REQ-021 TURN SHALL last one cycle with all lines released, then go to WDATA if rw=1, else RDATA; cnt reloads to 6.
REQ-022 WDATA SHALL drive data=wdata[cnt+:2] for 4 cycles, then go to WACK.
REQ-023 WACK SHALL release data for one cycle and sample ack; ACK -> STOP with err=0; NACK with retry count < MAX_RETRY -> increment it, reload cnt, go to WDATA; otherwise -> STOP with err=1.
REQ-024 RDATA SHALL sample data into rdata[cnt+:2] on 4 consecutive posedges, MSB pair first, with the master driving nothing.
REQ-025 RACK SHALL drive ack=0 for one cycle, then go to STOP with err=0.
REQ-026 STOP SHALL drive ctrl=11 for one cycle, pulse rsp_valid on exit, and return to IDLE.
REQ-027 The counter SHALL be 3 bits, decrement by 2 and never wrap below 0; the retry counter SHALL saturate at MAX_RETRY.
REQ-028 An error-free write with no retries SHALL take 13 cycles from accept to the rsp_valid pulse; each retry SHALL add 5 cycles.
REQ-029 The master SHALL never drive data and ack in the same cycle, and SHALL never drive ctrl while in HDR, HACK, TURN or RDATA.

Reset
REQ-030 rst_n low SHALL immediately put the block in IDLE, release all three inout lines, and clear req_ready-blocking state, rsp_valid, rsp_err, rsp_rdata, cnt and the retry count.
REQ-031 A reset mid-transaction SHALL abort the transaction with no STOP and no rsp_valid; req_ready SHALL go high on the first posedge after rst_n rises.

Structure
REQ-032 The ctrl encodings (START, OWN, STOP), the ACK polarity and the state encoding SHALL live in shared package fcp6_pkg, which the responder also uses.
REQ-033 The 2-bit beat shifter and counter SHALL be one sub-module, fcp6_beat_shifter, shared by the HDR, WDATA and RDATA states.

Verification
REQ-034 Write addr=0x2A, wdata=0xA5, responder ACKs both -> data beats 01,01,01,01 then 10,10,01,01; rsp_valid with err=0.
REQ-035 Read addr=0x15, responder returns 0x55 and ACKs the header -> header beats 00,10,10,10; rsp_rdata=0x55; master drives ack=0 in RACK.
REQ-036 Header NACK (ack floating) -> STOP follows HACK directly; no data beats; err=1.
REQ-037 Write with the data NACKed 4 times, MAX_RETRY=3 -> exactly 4 WDATA bursts, then STOP with err=1.
REQ-038 Deassert rst_n during the second WDATA beat -> all lines go z asynchronously; no rsp_valid; a new request is then accepted normally.
